cost_table: RTL and testbench

COST_TABLE -- requirements
Module: cost_table

---
 rtl/cost_table_if.sv | 51 +++++
 rtl/cost_table.sv | 103 ++++++++++
 tb/tb_cost_table.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/cost_table_if.sv
// Bus interface for cost_table: load handshake, read port and status.
// The in_par wire exists only when COST_PARITY_EN is defined.
interface cost_table_if;
   logic       load_start;
   logic       in_valid;
   logic [6:0] in_data;
`ifdef COST_PARITY_EN
   logic       in_par;
`endif
   logic       in_ready;
   logic [2:0] W;
   logic [2:0] J;
   logic [6:0] Cost;
   logic       table_ready;
   logic [6:0] load_cnt;
   logic       load_err;

   // Producer/consumer side (drives load data and read address).
   modport master (
      output load_start,
      output in_valid,
      output in_data,
`ifdef COST_PARITY_EN
      output in_par,
`endif
      output W,
      output J,
      input  in_ready,
      input  Cost,
      input  table_ready,
      input  load_cnt,
      input  load_err
   );

   // Cost table side.
   modport slave (
      input  load_start,
      input  in_valid,
      input  in_data,
`ifdef COST_PARITY_EN
      input  in_par,
`endif
      input  W,
      input  J,
      output in_ready,
      output Cost,
      output table_ready,
      output load_cnt,
      output load_err
   );
endinterface

// File: rtl/cost_table.sv
// 8x8 table of 7-bit costs, loaded row-major through a valid/ready stream and
// read combinationally by {W,J}. Reads return 0 until a full 64-word load completes.
// Optional macro COST_PARITY_EN adds in_par (even parity) and a sticky load_err.
module cost_table (
   input logic         CLK,
   input logic         RST,
   cost_table_if.slave bus
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] LOAD  = 2'd1;
   localparam logic [1:0] SERVE = 2'd2;

   localparam logic [6:0] LAST_IDX = 7'd63;

   logic [1:0] state_q, state_d;
   logic [6:0] cnt_q, cnt_d;
   logic [6:0] mem [64];
   logic       accept;

   // A word is taken only in LOAD; a same-cycle restart discards it.
   always_comb begin
      accept = (state_q == LOAD) && bus.in_valid && !bus.load_start;
   end

   // Next state and load counter; counter stops at 64 because LOAD exits on the 64th word.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.load_start) begin
               state_d = LOAD;
               cnt_d   = '0;
            end
         end
         LOAD: begin
            if (bus.load_start) begin
               cnt_d = '0;
            end else if (accept) begin
               cnt_d = cnt_q + 7'd1;
               if (cnt_q == LAST_IDX) begin
                  state_d = SERVE;
               end
            end
         end
         SERVE: begin
            if (bus.load_start) begin
               state_d = LOAD;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Storage write; not cleared by reset since reads are masked until a reload finishes.
   always_ff @(posedge CLK) begin
      if (!RST && accept) begin
         mem[cnt_q[5:0]] <= bus.in_data;
      end
   end

`ifdef COST_PARITY_EN
   logic err_q;

   // Sticky parity error, set one cycle after a bad word is accepted.
   always_ff @(posedge CLK) begin
      if (RST) begin
         err_q <= 1'b0;
      end else if (bus.load_start) begin
         err_q <= 1'b0;
      end else if (accept && (^{bus.in_data, bus.in_par})) begin
         err_q <= 1'b1;
      end
   end

   assign bus.load_err = err_q;
`else
   assign bus.load_err = 1'b0;
`endif

   // Status outputs and masked zero-latency read.
   always_comb begin
      bus.in_ready    = (state_q == LOAD);
      bus.table_ready = (state_q == SERVE);
      bus.load_cnt    = cnt_q;
      bus.Cost        = (state_q == SERVE) ? mem[{bus.W, bus.J}] : 7'd0;
   end
endmodule

// File: tb/tb_cost_table.sv
// Scoreboard bench for cost_table: stimulus posts expectations into a queue,
// a negedge monitor drains and compares them against the DUT outputs.
module tb_cost_table;
   logic CLK = 1'b0;
   logic RST = 1'b1;

   always #5 CLK = ~CLK;

   cost_table_if bus ();

   cost_table dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   typedef struct {
      bit         is_cost;
      logic [9:0] exp;
      string      tag;
   } exp_t;

   exp_t sb_q[$];
   int   n_run  = 0;
   int   n_fail = 0;
   logic exp_err = 1'b0;

   // Monitor: mid-cycle, compare every expectation posted for this cycle.
   always @(negedge CLK) begin
      exp_t       e;
      logic [9:0] act;
      while (sb_q.size() > 0) begin
         e   = sb_q.pop_front();
         act = e.is_cost ? {3'b000, bus.Cost}
                         : {bus.load_cnt, bus.table_ready, bus.in_ready, bus.load_err};
         n_run++;
         if (act !== e.exp) begin
            n_fail++;
            if (e.is_cost)
               $display("FAIL %s: Cost=%0d expected %0d (t=%0t)", e.tag, act, e.exp, $time);
            else
               $display("FAIL %s: {cnt,tr,ir,err}=%0d,%b,%b,%b expected %0d,%b,%b,%b (t=%0t)",
                        e.tag, act[9:3], act[2], act[1], act[0],
                        e.exp[9:3], e.exp[2], e.exp[1], e.exp[0], $time);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit, got no finish expected finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic exp_status(input string tag, input int cnt, input bit tr, input bit ir);
      exp_t e;
      e.is_cost = 1'b0;
      e.exp     = {cnt[6:0], tr, ir, exp_err};
      e.tag     = tag;
      sb_q.push_back(e);
   endtask

   task automatic exp_cost(input string tag, input int w, input int j, input int cost);
      exp_t e;
      bus.W     = w[2:0];
      bus.J     = j[2:0];
      e.is_cost = 1'b1;
      e.exp     = {3'b000, cost[6:0]};
      e.tag     = tag;
      sb_q.push_back(e);
   endtask

   function automatic int word_val(input int k, input bit alt);
      return alt ? (127 - k) : (k % 100);
   endfunction

   task automatic start_load();
      bus.load_start = 1'b1;
      bus.in_valid   = 1'b0;
      tick();
      bus.load_start = 1'b0;
      exp_err        = 1'b0;
   endtask

   // Feed words 0..n-1; optional idle gap before each word after the first.
   task automatic feed(input int n, input bit toggle, input bit alt, input int bad);
      for (int k = 0; k < n; k++) begin
         logic [6:0] d;
         bit         flip;
         if (toggle && k > 0) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 7'h7f;
            exp_status("load_gap", k, 1'b0, 1'b1);
            tick();
         end
         d            = 7'(word_val(k, alt));
         flip         = (k == bad);
         bus.in_valid = 1'b1;
         bus.in_data  = d;
`ifdef COST_PARITY_EN
         bus.in_par   = (^d) ^ flip;
`endif
         exp_status(flip ? "load_word_badpar" : "load_word", k, 1'b0, 1'b1);
         tick();
`ifdef COST_PARITY_EN
         if (flip) exp_err = 1'b1;
`endif
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic sweep(input string tag, input bit alt);
      for (int w = 0; w < 8; w++) begin
         for (int j = 0; j < 8; j++) begin
            exp_cost(tag, w, j, word_val(w * 8 + j, alt));
            tick();
         end
      end
   endtask

   initial begin
      bus.load_start = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      bus.W          = '0;
      bus.J          = '0;
`ifdef COST_PARITY_EN
      bus.in_par     = 1'b0;
`endif
      RST = 1'b1;
      tick();
      tick();
      exp_status("reset_state", 0, 1'b0, 1'b0);
      exp_cost("reset_cost", 3, 5, 0);

      // Reset beats load_start and in_valid.
      bus.load_start = 1'b1;
      bus.in_valid   = 1'b1;
      tick();
      exp_status("rst_priority", 0, 1'b0, 1'b0);
      bus.load_start = 1'b0;
      RST            = 1'b0;
      bus.in_data    = 7'h2a;
      tick();
      exp_status("idle_ignore", 0, 1'b0, 1'b0);
      bus.in_valid = 1'b0;
      tick();

      // Full streaming load, then complete sweep.
      start_load();
      feed(64, 1'b0, 1'b0, -1);
      exp_status("load_done", 64, 1'b1, 1'b0);
      sweep("sweep_plain", 1'b0);

      // Words offered in SERVE are ignored.
      bus.in_valid = 1'b1;
      bus.in_data  = 7'h7f;
      for (int i = 0; i < 3; i++) begin
         exp_status("serve_ignore", 64, 1'b1, 1'b0);
         tick();
      end
      bus.in_valid = 1'b0;
      exp_cost("serve_keep_77", 7, 7, 63);
      tick();
      exp_cost("serve_keep_12", 1, 2, 10);
      tick();

      // Toggled valid with different data; reads hidden while loading.
      start_load();
      exp_cost("hidden_in_load", 1, 2, 0);
      feed(64, 1'b1, 1'b1, -1);
      exp_status("toggle_done", 64, 1'b1, 1'b0);
      sweep("sweep_toggle", 1'b1);

      // Restart at load_cnt=30 with a same-cycle word.
      start_load();
      feed(30, 1'b0, 1'b0, -1);
      bus.load_start = 1'b1;
      bus.in_valid   = 1'b1;
      bus.in_data    = 7'h55;
      exp_status("restart_cnt30", 30, 1'b0, 1'b1);
      tick();
      bus.load_start = 1'b0;
      bus.in_valid   = 1'b0;
      exp_err        = 1'b0;
      exp_status("restart_cnt0", 0, 1'b0, 1'b1);
      exp_cost("restart_hidden", 0, 0, 0);
      tick();
      feed(64, 1'b0, 1'b0, -1);
      exp_status("restart_done", 64, 1'b1, 1'b0);
      sweep("sweep_restart", 1'b0);

      // Reset at load_cnt=40 aborts; later words ignored.
      start_load();
      feed(40, 1'b0, 1'b1, -1);
      RST          = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 7'h11;
      exp_status("rst_cnt40", 40, 1'b0, 1'b1);
      tick();
      RST     = 1'b0;
      exp_err = 1'b0;
      exp_status("rst_abort", 0, 1'b0, 1'b0);
      exp_cost("rst_cost", 0, 0, 0);
      tick();
      for (int i = 0; i < 3; i++) begin
         exp_status("rst_ignore", 0, 1'b0, 1'b0);
         tick();
      end
      bus.in_valid = 1'b0;

      // Load with word 10 carrying bad parity (only meaningful with COST_PARITY_EN).
      start_load();
      feed(64, 1'b0, 1'b0, 10);
      exp_status("parity_done", 64, 1'b1, 1'b0);
      sweep("sweep_parity", 1'b0);
      exp_status("err_in_serve", 64, 1'b1, 1'b0);
      bus.load_start = 1'b1;
      tick();
      bus.load_start = 1'b0;
      exp_err        = 1'b0;
      exp_status("err_cleared", 0, 1'b0, 1'b1);
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
